alu_uart_loader: RTL and testbench

ALU_UART_LOADER -- requirements
Module: alu_uart_loader

---
 rtl/alu_uart_loader.sv | 91 +++++++++
 tb/tb_alu_uart_loader.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/alu_uart_loader.sv
// alu_uart_loader: collects operand A, operand B and opcode bytes from a UART, then returns the ALU result.
// Define ALU_IF_TIMEOUT_EN to compile in the inter-byte timeout that aborts a partial frame.
module alu_uart_loader #(
  parameter int NB_DATA        = 8,
  parameter int NB_OPCODE      = 6,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NB_DATA-1:0]   rx_data,
  input  logic                 rx_done,
  input  logic [NB_DATA-1:0]   alu_result,
  input  logic                 tx_busy,
  output logic [NB_DATA-1:0]   dato_a,
  output logic [NB_DATA-1:0]   dato_b,
  output logic [NB_OPCODE-1:0] opcode,
  output logic [NB_DATA-1:0]   tx_data,
  output logic                 tx_start,
  output logic                 timeout
);
  typedef enum logic [2:0] {RX_A, RX_B, RX_OP, WAIT_ALU, SEND} state_t;
  state_t               state_q, state_d;
  logic [NB_DATA-1:0]   a_q, a_d, b_q, b_d, tx_q, tx_d;
  logic [NB_OPCODE-1:0] op_q, op_d;
  logic                 start_q, start_d, to_q, to_d;
`ifdef ALU_IF_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    tx_d    = tx_q;
    start_d = 1'b0;
    to_d    = 1'b0;
    case (state_q)
      RX_A:     if (rx_done) begin a_d = rx_data; state_d = RX_B; end
      RX_B:     if (rx_done) begin b_d = rx_data; state_d = RX_OP; end
      RX_OP:    if (rx_done) begin op_d = rx_data[NB_OPCODE-1:0]; state_d = WAIT_ALU; end
      WAIT_ALU: begin tx_d = alu_result; state_d = SEND; end
      SEND:     if (!tx_busy) begin start_d = 1'b1; state_d = RX_A; end
      default:  state_d = RX_A;
    endcase
`ifdef ALU_IF_TIMEOUT_EN
    // Counter is zero outside the waits, so entering RX_B/RX_OP always starts from 0; rx_done wins over expiry.
    cnt_d = '0;
    if ((state_q == RX_B || state_q == RX_OP) && !rx_done) begin
      if (cnt_q == CNT_LAST) begin
        state_d = RX_A;
        to_d    = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
`endif
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RX_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      tx_q    <= '0;
      start_q <= 1'b0;
      to_q    <= 1'b0;
`ifdef ALU_IF_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      tx_q    <= tx_d;
      start_q <= start_d;
      to_q    <= to_d;
`ifdef ALU_IF_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end
  assign dato_a   = a_q;
  assign dato_b   = b_q;
  assign opcode   = op_q;
  assign tx_data  = tx_q;
  assign tx_start = start_q;
  assign timeout  = to_q;
endmodule

// File: tb/tb_alu_uart_loader.sv
// tb_alu_uart_loader: directed and randomized frames checked against an expected-register model and an ALU model.
module tb_alu_uart_loader;
  localparam int NB_DATA   = 8;
  localparam int NB_OPCODE = 6;
  localparam int TO        = 16;
  logic clk = 1'b0, reset = 1'b1, rx_done = 1'b0, tx_busy = 1'b0;
  logic [NB_DATA-1:0] rx_data = '0, alu_result, dato_a, dato_b, tx_data;
  logic [NB_OPCODE-1:0] opcode;
  logic tx_start, timeout;
  int vectors = 0, errors = 0;
  logic [7:0] ea = '0, eb = '0, etx = '0;
  logic [5:0] eop = '0;
  logic [5:0] ops [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};

  alu_uart_loader #(.NB_DATA(NB_DATA), .NB_OPCODE(NB_OPCODE), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done), .alu_result(alu_result),
    .tx_busy(tx_busy), .dato_a(dato_a), .dato_b(dato_b), .opcode(opcode), .tx_data(tx_data),
    .tx_start(tx_start), .timeout(timeout));

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      6'h03:   return 8'($signed(a) >>> b[2:0]);
      6'h02:   return a >> b[2:0];
      default: return 8'h00;
    endcase
  endfunction

  assign alu_result = alu_f(dato_a, dato_b, opcode);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, ".dato_a"}, 32'(dato_a), 32'(ea));
    chk({tag, ".dato_b"}, 32'(dato_b), 32'(eb));
    chk({tag, ".opcode"}, 32'(opcode), 32'(eop));
    chk({tag, ".tx_data"}, 32'(tx_data), 32'(etx));
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk); #1;
    rx_done = 1'b0;
    rx_data = 8'($urandom);
  endtask

  // Called just after the opcode byte was taken (cycle N+1); pulse expected in cycle N+3+busy.
  task automatic tail(input int busy, input bit inj);
    if (inj) begin rx_done = 1'b1; rx_data = 8'($urandom); end
    @(negedge clk);
    chk("wait.tx_start", 32'(tx_start), 0);
    chk_regs("wait");
    @(posedge clk); #1;
    etx = alu_f(ea, eb, eop);
    if (inj) rx_data = 8'($urandom);
    for (int i = 0; i <= busy; i++) begin
      if (i == busy) tx_busy = 1'b0;
      @(negedge clk);
      chk("send.tx_start", 32'(tx_start), 0);
      chk_regs("send");
      @(posedge clk); #1;
      rx_done = 1'b0;
    end
    @(negedge clk);
    chk("pulse.tx_start", 32'(tx_start), 1);
    chk("pulse.timeout", 32'(timeout), 0);
    chk_regs("pulse");
    @(posedge clk); #1;
    @(negedge clk);
    chk("after.tx_start", 32'(tx_start), 0);
    @(posedge clk); #1;
  endtask

  task automatic do_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                          input int busy, input bit inj);
    send_byte(a); ea = a;
    idle($urandom_range(0, 3));
    send_byte(b); eb = b;
    idle($urandom_range(0, 3));
    tx_busy = (busy > 0);
    send_byte(opb); eop = opb[5:0];
    tail(busy, inj);
  endtask

  initial begin
    int n;
    #1;
    chk_regs("reset");
    chk("reset.tx_start", 32'(tx_start), 0);
    chk("reset.timeout", 32'(timeout), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(2);

    do_frame(8'h05, 8'h03, 8'h20, 0, 0);
    chk("add.tx_data", 32'(tx_data), 32'h08);
    do_frame(8'h05, 8'h07, 8'hE2, 0, 0);
    chk("sub.opcode", 32'(opcode), 32'h22);
    chk("sub.tx_data", 32'(tx_data), 32'hFE);
    do_frame(8'h40, 8'h02, 8'h26, 10, 0);
    do_frame(8'h9C, 8'h11, 8'h24, 2, 1);

    send_byte(8'h11); ea = 8'h11;
    send_byte(8'h22); eb = 8'h22;
    #2 reset = 1'b1;
    #1;
    ea = '0; eb = '0; eop = '0; etx = '0;
    chk_regs("midreset");
    chk("midreset.tx_start", 32'(tx_start), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    n = 0;
    repeat (4) begin @(negedge clk); if (tx_start) n++; @(posedge clk); #1; end
    chk("midreset.no_start", 32'(n), 0);
    do_frame(8'h01, 8'h02, 8'h20, 0, 0);
    chk("postreset.tx_data", 32'(tx_data), 32'h03);

    send_byte(8'h3A); ea = 8'h3A;
    n = 0;
    repeat (TO + 4) begin @(negedge clk); if (timeout) n++; @(posedge clk); #1; end
`ifdef ALU_IF_TIMEOUT_EN
    chk("timeout.pulses", 32'(n), 1);
    send_byte(8'h5B); ea = 8'h5B;
    chk("timeout.dato_a", 32'(dato_a), 32'h5B);
    send_byte(8'h04); eb = 8'h04;
`else
    chk("timeout.pulses", 32'(n), 0);
    send_byte(8'h5B); eb = 8'h5B;
    chk("timeout.dato_b", 32'(dato_b), 32'h5B);
`endif
    send_byte(8'h20); eop = 6'h20;
    tail(0, 0);

    for (int k = 0; k < 20; k++)
      do_frame(8'($urandom), 8'($urandom), {2'($urandom), ops[$urandom_range(0, 7)]},
               $urandom_range(0, 3), 1'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
